// File: rtl/ir_pkg.sv
// Shared definitions for the NEC IR key-event path: FSM states, frame field
// offsets and the release-timeout load computation.
package ir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
  } ir_state_t;

  localparam int unsigned ADDR_LO = 0;
  localparam int unsigned ADDR_HI = 8;
  localparam int unsigned CMD     = 16;
  localparam int unsigned CMD_N   = 24;

  // Down-counter load value: the timer spends load+1 cycles before expiring.
  function automatic int unsigned rel_load(input int unsigned clk_hz,
                                           input int unsigned rel_ms);
    return clk_hz / 1000 * rel_ms - 1;
  endfunction

endpackage

// File: rtl/ir_rel_timer.sv
// Loadable release down-counter; expires when it sits at zero while running
// and is not being reloaded in the same cycle.
module ir_rel_timer #(
  parameter int unsigned LOAD_VAL = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_run,
  output logic o_expire
);

  localparam int unsigned W = $clog2(LOAD_VAL) + 1;
  localparam logic [W-1:0] LOAD = W'(LOAD_VAL);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (i_load) begin
      cnt <= LOAD;
    end else if (i_run && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign o_expire = i_run && !i_load && (cnt == '0);

endmodule

// File: rtl/ir_key_dec.sv
// NEC key-event decoder: frame integrity/address check, press/auto-repeat/
// release FSM, last-key hold registers and saturating reject counter.
module ir_key_dec
  import ir_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned RELEASE_MS = 120,
  parameter int unsigned AUTO_REP   = 4,
  parameter bit          EXT_ADDR   = 1'b0,
  parameter bit          ADDR_EN    = 1'b0,
  parameter logic [15:0] ADDR_VAL   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_frame,
  input  logic        i_frame_vld,
  input  logic        i_repeat,
  output logic [7:0]  o_key,
  output logic [15:0] o_addr,
  output logic        o_key_vld,
  output logic        o_key_rep,
  output logic        o_key_hold,
  output logic        o_release,
  output logic        o_err,
  output logic [7:0]  o_err_cnt
);

  ir_state_t   state;
  logic [7:0]  rep_cnt;
  logic [7:0]  rep_inc;

  logic [7:0]  a_lo, a_hi, cmd, cmd_n;
  logic [15:0] f_addr;
  logic        cmd_ok, cpl_ok, filt_ok, frame_ok;
  logic        accept, reject, rep_act;
  logic        tmr_load, tmr_run, tmr_expire;

  assign a_lo  = i_frame[ADDR_LO +: 8];
  assign a_hi  = i_frame[ADDR_HI +: 8];
  assign cmd   = i_frame[CMD     +: 8];
  assign cmd_n = i_frame[CMD_N   +: 8];

  assign f_addr  = EXT_ADDR ? {a_hi, a_lo} : {8'h00, a_lo};
  assign cmd_ok  = (cmd_n == ~cmd);
  assign cpl_ok  = EXT_ADDR || (a_hi == ~a_lo);
  assign filt_ok = !ADDR_EN ||
                   (EXT_ADDR ? (f_addr == ADDR_VAL) : (a_lo == ADDR_VAL[7:0]));
  assign frame_ok = cmd_ok && cpl_ok && filt_ok;

  assign accept  = i_frame_vld && frame_ok;
  assign reject  = i_frame_vld && !frame_ok;
  assign rep_act = i_repeat && !i_frame_vld && (state != IDLE);

  // A rejected frame freezes the timer so no release can coincide with o_err.
  assign tmr_load = accept || rep_act;
  assign tmr_run  = (state != IDLE) && !reject;

  assign rep_inc = (rep_cnt == 8'hFF) ? rep_cnt : rep_cnt + 8'd1;

  ir_rel_timer #(
    .LOAD_VAL (rel_load(CLK_HZ, RELEASE_MS))
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (tmr_load),
    .i_run    (tmr_run),
    .o_expire (tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rep_cnt    <= '0;
      o_key      <= '0;
      o_addr     <= '0;
      o_key_vld  <= 1'b0;
      o_key_rep  <= 1'b0;
      o_key_hold <= 1'b0;
      o_release  <= 1'b0;
      o_err      <= 1'b0;
      o_err_cnt  <= '0;
    end else begin
      o_key_vld <= 1'b0;
      o_key_rep <= 1'b0;
      o_release <= 1'b0;
      o_err     <= 1'b0;
      if (accept) begin
        o_key      <= cmd;
        o_addr     <= f_addr;
        o_key_vld  <= 1'b1;
        o_key_hold <= 1'b1;
        rep_cnt    <= '0;
        state      <= PRESS;
      end else if (reject) begin
        o_err <= 1'b1;
        if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
      end else if (rep_act) begin
        case (state)
          PRESS: begin
            rep_cnt <= rep_inc;
            if (32'(rep_inc) == AUTO_REP) begin
              state     <= HOLD;
              o_key_vld <= 1'b1;
              o_key_rep <= 1'b1;
            end
          end
          HOLD: begin
            o_key_vld <= 1'b1;
            o_key_rep <= 1'b1;
          end
          default: ;
        endcase
      end else if (tmr_expire) begin
        o_release  <= 1'b1;
        o_key_hold <= 1'b0;
        state      <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ir_key_dec.sv
// Directed bench for ir_key_dec: default config plus address-filter and
// extended-address instances, all with a 10-cycle release timeout.
module tb_ir_key_dec;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_frame = '0;
  logic        i_frame_vld = 1'b0;
  logic        i_repeat = 1'b0;

  logic [7:0]  key0, key1, key2;
  logic [15:0] addr0, addr1, addr2;
  logic        vld0, vld1, vld2, rep0, rep1, rep2, hold0, hold1, hold2;
  logic        rel0, rel1, rel2, err0, err1, err2;
  logic [7:0]  ecnt0, ecnt1, ecnt2;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  ir_key_dec #(.CLK_HZ(1000), .RELEASE_MS(10), .AUTO_REP(4)) dut0 (
    .clk(clk), .rst(rst), .i_frame(i_frame), .i_frame_vld(i_frame_vld),
    .i_repeat(i_repeat), .o_key(key0), .o_addr(addr0), .o_key_vld(vld0),
    .o_key_rep(rep0), .o_key_hold(hold0), .o_release(rel0), .o_err(err0),
    .o_err_cnt(ecnt0));

  ir_key_dec #(.CLK_HZ(1000), .RELEASE_MS(10), .AUTO_REP(4),
               .ADDR_EN(1'b1), .ADDR_VAL(16'h0004)) dut1 (
    .clk(clk), .rst(rst), .i_frame(i_frame), .i_frame_vld(i_frame_vld),
    .i_repeat(i_repeat), .o_key(key1), .o_addr(addr1), .o_key_vld(vld1),
    .o_key_rep(rep1), .o_key_hold(hold1), .o_release(rel1), .o_err(err1),
    .o_err_cnt(ecnt1));

  ir_key_dec #(.CLK_HZ(1000), .RELEASE_MS(10), .AUTO_REP(4),
               .EXT_ADDR(1'b1)) dut2 (
    .clk(clk), .rst(rst), .i_frame(i_frame), .i_frame_vld(i_frame_vld),
    .i_repeat(i_repeat), .o_key(key2), .o_addr(addr2), .o_key_vld(vld2),
    .o_key_rep(rep2), .o_key_hold(hold2), .o_release(rel2), .o_err(err2),
    .o_err_cnt(ecnt2));

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [31:0] f);
    i_frame     = f;
    i_frame_vld = 1'b1;
    tick(1);
    i_frame_vld = 1'b0;
  endtask

  task automatic send_repeat();
    i_repeat = 1'b1;
    tick(1);
    i_repeat = 1'b0;
  endtask

  initial begin
    tick(2);
    rst = 1'b0;

    check("rst_key", key0, 8'h00);
    check("rst_addr", addr0, 16'h0000);
    check("rst_flags", {vld0, rep0, hold0, rel0, err0}, 5'b0);
    check("rst_ecnt", ecnt0, 8'h00);

    send_repeat();
    check("idle_rep", {vld0, rep0, hold0, rel0, err0}, 5'b0);
    check("idle_rep_key", key0, 8'h00);

    // press, then release 10 cycles after the load
    send_frame(32'hBF40_FF00);
    check("press_flags", {vld0, rep0, hold0, rel0, err0}, 5'b10100);
    check("press_key", key0, 8'h40);
    check("press_addr", addr0, 16'h0000);
    tick(1);
    check("press_vld_1cyc", vld0, 1'b0);
    tick(8);
    check("pre_release", {rel0, hold0}, 2'b01);
    tick(1);
    check("release", {rel0, hold0, vld0}, 3'b100);
    check("release_key_kept", key0, 8'h40);
    tick(1);
    check("release_1cyc", rel0, 1'b0);

    send_frame(32'hBE40_FF00);
    check("bad_cmd_flags", {vld0, hold0, rel0, err0}, 4'b0001);
    check("bad_cmd_cnt", ecnt0, 8'd1);
    check("bad_cmd_key", key0, 8'h40);
    tick(1);
    check("bad_cmd_1cyc", err0, 1'b0);

    // auto-repeat after the 4th repeat code
    send_frame(32'hED12_FF00);
    check("rpress_key", {vld0, rep0, key0}, {2'b10, 8'h12});
    for (int unsigned r = 1; r <= 6; r++) begin
      tick(4);
      send_repeat();
      check($sformatf("rep%0d_vld", r), {vld0, rep0}, (r >= 4) ? 2'b11 : 2'b00);
      check($sformatf("rep%0d_key", r), {hold0, key0}, {1'b1, 8'h12});
    end
    tick(9);
    check("hold_pre_release", {rel0, hold0}, 2'b01);
    tick(1);
    check("hold_release", {rel0, hold0}, 2'b10);
    tick(1);

    // frame and repeat together: exactly one press
    i_repeat = 1'b1;
    send_frame(32'hBF40_FF00);
    i_repeat = 1'b0;
    check("simul_press", {vld0, rep0, key0}, {2'b10, 8'h40});
    tick(1);
    check("simul_single", vld0, 1'b0);

    // reach HOLD, then reset
    for (int unsigned r = 1; r <= 4; r++) begin
      tick(1);
      send_repeat();
    end
    check("hold_entry", {vld0, rep0, hold0}, 3'b111);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_flags", {vld0, rep0, hold0, rel0, err0}, 5'b0);
    check("midrst_regs", {key0, addr0, ecnt0}, 32'h0);
    for (int unsigned i = 0; i < 11; i++) begin
      tick(1);
      check("midrst_no_rel", rel0, 1'b0);
    end
    send_repeat();
    check("midrst_rep_ign", {vld0, hold0}, 2'b00);

    // back-to-back bad frames saturate the counter
    i_frame     = 32'hBE40_FF00;
    i_frame_vld = 1'b1;
    for (int unsigned i = 0; i < 256; i++) begin
      tick(1);
      if (i == 2) check("b2b_cnt3", {err0, ecnt0}, {1'b1, 8'd3});
    end
    i_frame_vld = 1'b0;
    check("sat_cnt", ecnt0, 8'd255);
    send_frame(32'hBE40_FF00);
    check("sat_hold", {err0, ecnt0}, {1'b1, 8'd255});
    tick(1);

    // address filter and extended address
    send_frame(32'hBF40_FF00);
    check("filt_reject", {vld1, err1}, 2'b01);
    tick(1);
    send_frame(32'hBF40_FB04);
    check("filt_accept", {vld1, err1}, 2'b10);
    check("filt_addr", addr1, 16'h0004);
    tick(1);
    send_frame(32'hEF10_3412);
    check("ext_accept", {vld2, err2, key2}, {2'b10, 8'h10});
    check("ext_addr", addr2, 16'h3412);
    check("std_cpl_err", {vld0, err0}, 2'b01);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ir_key_dec.md
# ir_key_dec

Key-event decoder between the NEC IR receiver and the display/application logic. It consumes 32-bit NEC frames and repeat-code strobes, checks frame integrity and address, and emits press, auto-repeat and release events. It also holds the last valid key for the display path. It runs entirely in the system `clk` domain; the receiver delivers one-cycle strobes already synchronised to `clk`.

## Interface
- `CLK_HZ`, 50_000_000: `clk` frequency in Hz.
- `RELEASE_MS`, 120: key-release timeout in ms after the last frame or repeat code.
- `AUTO_REP`, 4: repeat codes needed before the key enters auto-repeat.
- `EXT_ADDR`, 0: 0 = 8-bit address with complement check; 1 = 16-bit extended address with no check.
- `ADDR_EN`, 0: 1 = accept only frames whose address equals `ADDR_VAL`.
- `ADDR_VAL`, 16'h0000: address filter value. With `EXT_ADDR`=0 only the low byte is compared.

Ports:
- `clk` in 1: system clock, single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `i_frame` in 32: NEC frame. [7:0] addr, [15:8] ~addr or addr high byte, [23:16] cmd, [31:24] ~cmd.
- `i_frame_vld` in 1: one-cycle strobe; `i_frame` is valid in that cycle.
- `i_repeat` in 1: one-cycle strobe for a received NEC repeat code.
- `o_key` out 8: last accepted command.
- `o_addr` out 16: last accepted address. Upper byte is 0 when `EXT_ADDR`=0.
- `o_key_vld` out 1: one-cycle key event (press or auto-repeat).
- `o_key_rep` out 1: qualifies `o_key_vld`. 0 = press, 1 = auto-repeat.
- `o_key_hold` out 1: level, high while state is PRESS or HOLD.
- `o_release` out 1: one-cycle strobe when the release timeout expires.
- `o_err` out 1: one-cycle strobe on a rejected frame.
- `o_err_cnt` out 8: count of rejected frames, saturates at 255.

## Operation
- Frame check:
  - Command check passes when `i_frame[31:24] == ~i_frame[23:16]`.
  - With `EXT_ADDR`=0, the address check also requires `[15:8] == ~[7:0]`.
  - With `ADDR_EN`=1, the address must equal the filter value.
  - Any check failing rejects the frame.
- Accepted frame, in any state:
  - latch `o_key`/`o_addr`;
  - pulse `o_key_vld` with `o_key_rep`=0;
  - clear the repeat counter;
  - load the release timer;
  - go to PRESS.
- Rejected frame: pulse `o_err` and increment `o_err_cnt` (saturating). State, timer and key registers are unchanged.
- States:
  - IDLE: `i_repeat` is ignored.
  - PRESS: `i_repeat` reloads the timer and increments the repeat counter (saturating at 255). When the counter reaches `AUTO_REP`, go to HOLD and emit `o_key_vld` with `o_key_rep`=1.
  - HOLD: each `i_repeat` reloads the timer and emits `o_key_vld` with `o_key_rep`=1 and the same `o_key`.
  - PRESS/HOLD timer expiry: pulse `o_release` and go to IDLE. `o_key`/`o_addr` keep their last value.
- Release timer: down-counter loaded with `CLK_HZ/1000*RELEASE_MS - 1`. Width is `$clog2` of the load value, plus 1. It expires when it reaches 0 in PRESS/HOLD.
- Simultaneous `i_frame_vld` and `i_repeat`: the frame is processed and the repeat is dropped.
- Timer expiry in the same cycle as an accepted frame or `i_repeat`: the reload wins, with no `o_release`.

## Timing
- All outputs are registered.
- Events appear in the cycle after the input strobe (1-cycle latency).
- `o_key_vld`, `o_release` and `o_err` are exactly one cycle wide. They are never asserted together except `o_err` with nothing else.
- Reset values:
  - all outputs 0, including `o_key`, `o_addr`, `o_err_cnt`;
  - state IDLE, timer 0, repeat counter 0.
- `rst` asserted mid-press returns to IDLE the next cycle with no `o_release` pulse.
- Back-to-back strobes on consecutive cycles are each processed, with no lost events.

## Structure
- Shared package `ir_pkg` holds:
  - state enum (IDLE, PRESS, HOLD);
  - NEC field offsets (ADDR_LO, ADDR_HI, CMD, CMD_N);
  - the release-time computation function.
- One sub-module, `ir_rel_timer`: a loadable down-counter with `i_load`, `i_run` and `o_expire`, parameterised by load value.
- Frame check and FSM stay in `ir_key_dec`.

## Test plan
All scenarios use `CLK_HZ`=1000 and `RELEASE_MS`=10, so the timeout is 10 cycles.
- Frame 32'hBF40_FF00 strobed → next cycle `o_key_vld`=1, `o_key_rep`=0, `o_key`=8'h40, `o_addr`=16'h0000, `o_key_hold`=1. The 10th cycle after load gives `o_release`=1 and `o_key_hold`=0.
- Frame 32'hBE40_FF00 (bad ~cmd) → `o_err` pulse, `o_err_cnt`=1, no `o_key_vld`, state unchanged. 256 bad frames → `o_err_cnt`=255.
- Valid frame, then 6 `i_repeat` strobes 5 cycles apart with `AUTO_REP`=4 → repeats 1–3 give no event; the 4th and later each give `o_key_vld` with `o_key_rep`=1. Release occurs 10 cycles after the last repeat.
- `i_repeat` in IDLE after reset → no outputs change. `i_frame_vld` and `i_repeat` in the same cycle → exactly one press event.
- `ADDR_EN`=1, `ADDR_VAL`=16'h0004: frame addr 00 → `o_err`; addr 04 → accepted. `EXT_ADDR`=1 with frame 32'hEF10_3412 → `o_addr`=16'h3412, no address-complement error.
- `rst` pulsed while in HOLD → all outputs 0 next cycle, no `o_release`. A following repeat is ignored.
